alineador_serial_ctrl: RTL and testbench



---
 rtl/alineador_serial_ctrl.sv | 173 +++++++++++++++++
 tb/tb_alineador_serial_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alineador_serial_ctrl.sv
// alineador_serial_ctrl: comma-based word aligner and sync FSM for the 10-bit
// 8b/10b serial receive path. Finds K28.5 (either disparity) in the raw bit
// stream, fixes the word boundary and presents framed words with a valid pulse.
//
// Optional build macro: ALINEADOR_ESTADISTICAS_EN
//   defined   -> perdidas_sync counts SYNCED -> SYNC_LOST transitions (saturating)
//   undefined -> perdidas_sync is tied to zero
module alineador_serial_ctrl #(
    parameter int unsigned                 cantidadBits = 10,
    parameter int unsigned                 COMMAS_LOCK  = 3,
    parameter int unsigned                 ERR_UNLOCK   = 4,
    parameter logic [cantidadBits-1:0]     COMMA_NEG    = 10'h17C,
    parameter logic [cantidadBits-1:0]     COMMA_POS    = 10'h283
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    entrada,
    output logic [cantidadBits-1:0] datos,
    output logic                    dato_valido,
    output logic                    sincronizado,
    output logic                    comma_detectado,
    output logic [3:0]              fase,
    output logic [7:0]              perdidas_sync
);

    localparam logic [1:0] SYNC_LOST = 2'd0;
    localparam logic [1:0] ACQUIRE   = 2'd1;
    localparam logic [1:0] SYNCED    = 2'd2;

    localparam int unsigned GoodW   = $clog2(COMMAS_LOCK + 1);
    localparam int unsigned ErrW    = $clog2(ERR_UNLOCK + 1);
    localparam logic [3:0]  FaseMax = 4'(cantidadBits - 1);

    // Only the 9 previous bits need storing; the newest bit comes straight
    // from the input pin to complete the window.
    logic [cantidadBits-2:0] sr_q, sr_d;
    logic [cantidadBits-1:0] ventana;
    logic [3:0]              fase_q, fase_d;
    logic [1:0]              estado_q, estado_d;
    logic [GoodW-1:0]        good_q, good_d;
    logic [ErrW-1:0]         err_q, err_d;
    logic [cantidadBits-1:0] datos_q, datos_d;
    logic                    valido_q, valido_d;
    logic                    comma_q;
    logic                    es_comma;
    logic                    frontera;

`ifdef ALINEADOR_ESTADISTICAS_EN
    logic [7:0]              perdidas_q, perdidas_d;
`endif

    // Window: newest bit in the MSB, oldest bit in bit0.
    assign ventana  = {entrada, sr_q};
    assign es_comma = (ventana == COMMA_NEG) || (ventana == COMMA_POS);
    assign frontera = (fase_q == FaseMax);

    // Next-state logic: phase tracking, acquire/lock/loss FSM and word capture.
    always_comb begin
        sr_d     = ventana[cantidadBits-1:1];
        fase_d   = frontera ? 4'd0 : fase_q + 4'd1;
        estado_d = estado_q;
        good_d   = good_q;
        err_d    = err_q;
        datos_d  = datos_q;
        valido_d = 1'b0;
`ifdef ALINEADOR_ESTADISTICAS_EN
        perdidas_d = perdidas_q;
`endif

        case (estado_q)
            SYNC_LOST: begin
                if (es_comma) begin
                    fase_d   = 4'd0;
                    good_d   = GoodW'(1);
                    estado_d = ACQUIRE;
                end
            end

            ACQUIRE: begin
                if (es_comma) begin
                    if (frontera) begin
                        if (good_q >= GoodW'(COMMAS_LOCK - 1)) begin
                            good_d   = GoodW'(COMMAS_LOCK);
                            err_d    = '0;
                            estado_d = SYNCED;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        // Comma at a new phase: restart the count there.
                        fase_d = 4'd0;
                        good_d = GoodW'(1);
                    end
                end
            end

            SYNCED: begin
                if (frontera) begin
                    datos_d  = ventana;
                    valido_d = 1'b1;
                end
                if (es_comma) begin
                    if (frontera) begin
                        err_d = '0;
                    end else if (err_q >= ErrW'(ERR_UNLOCK - 1)) begin
                        // Phase is deliberately left alone; SYNC_LOST realigns.
                        err_d    = '0;
                        good_d   = '0;
                        estado_d = SYNC_LOST;
`ifdef ALINEADOR_ESTADISTICAS_EN
                        if (perdidas_q != 8'hFF) begin
                            perdidas_d = perdidas_q + 8'd1;
                        end
`endif
                    end else begin
                        err_d = err_q + 1'b1;
                    end
                end
            end

            default: begin
                estado_d = SYNC_LOST;
                good_d   = '0;
                err_d    = '0;
            end
        endcase
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q     <= '0;
            fase_q   <= 4'd0;
            estado_q <= SYNC_LOST;
            good_q   <= '0;
            err_q    <= '0;
            datos_q  <= '0;
            valido_q <= 1'b0;
            comma_q  <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            fase_q   <= fase_d;
            estado_q <= estado_d;
            good_q   <= good_d;
            err_q    <= err_d;
            datos_q  <= datos_d;
            valido_q <= valido_d;
            comma_q  <= es_comma;
        end
    end

`ifdef ALINEADOR_ESTADISTICAS_EN
    // Sync-loss statistics counter, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perdidas_q <= 8'h00;
        end else begin
            perdidas_q <= perdidas_d;
        end
    end

    assign perdidas_sync = perdidas_q;
`else
    assign perdidas_sync = 8'h00;
`endif

    assign datos           = datos_q;
    assign dato_valido     = valido_q;
    assign sincronizado    = (estado_q == SYNCED);
    assign comma_detectado = comma_q;
    assign fase            = fase_q;

endmodule

// File: tb/tb_alineador_serial_ctrl.sv
// Self-checking bench for alineador_serial_ctrl. A reference model tracks the
// word phase as (bit index - last realign index) mod 10 and the sync state as
// plain counters; every output is compared after every clock edge.
module tb_alineador_serial_ctrl;

    localparam logic [9:0] KNEG = 10'h17C;
    localparam logic [9:0] KPOS = 10'h283;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       entrada = 1'b0;
    logic [9:0] datos;
    logic       dato_valido;
    logic       sincronizado;
    logic       comma_detectado;
    logic [3:0] fase;
    logic [7:0] perdidas_sync;

    int checks = 0;
    int errors = 0;

    alineador_serial_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .entrada         (entrada),
        .datos           (datos),
        .dato_valido     (dato_valido),
        .sincronizado    (sincronizado),
        .comma_detectado (comma_detectado),
        .fase            (fase),
        .perdidas_sync   (perdidas_sync)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         n;        // edges since reset
    int         r;        // edge of last realign (-1: none)
    logic [9:0] win;
    int         m_state;  // 0 lost, 1 acquire, 2 synced
    int         good;
    int         err;
    int         losses;
    logic [9:0] m_datos;
    logic       m_valid;
    logic       m_comma;
    int         m_fase;

    logic       stim[$];

    function automatic logic [25:0] dut_vec();
        return {datos, dato_valido, sincronizado, comma_detectado, fase, perdidas_sync};
    endfunction

    function automatic logic [25:0] exp_vec();
        logic [7:0] p;
`ifdef ALINEADOR_ESTADISTICAS_EN
        p = 8'(losses);
`else
        p = 8'h00;
`endif
        return {m_datos, m_valid, (m_state == 2), m_comma, 4'(m_fase), p};
    endfunction

    function automatic void model_clear();
        n = 0; r = -1; win = '0; m_state = 0; good = 0; err = 0; losses = 0;
        m_datos = '0; m_valid = 0; m_comma = 0; m_fase = 0;
    endfunction

    function automatic void add_word(input logic [9:0] w);
        for (int k = 0; k < 10; k++) stim.push_back(w[k]);
    endfunction

    function automatic void add_bits(input logic [9:0] v, input int cnt);
        for (int k = 0; k < cnt; k++) stim.push_back(v[k]);
    endfunction

    // Drive one bit, clock it in and advance the model.
    task automatic drive_bit(input logic b);
        logic c, bnd;
        entrada = b;
        @(posedge clk);
        #1;
        win = {b, win[9:1]};
        c   = (win == KNEG) || (win == KPOS);
        bnd = ((n - r) % 10) == 0;
        m_valid = 1'b0;
        if (m_state == 0) begin
            if (c) begin r = n; good = 1; m_state = 1; end
        end else if (m_state == 1) begin
            if (c && bnd) begin
                good++;
                if (good >= 3) begin m_state = 2; err = 0; end
            end else if (c) begin
                r = n; good = 1;
            end
        end else begin
            if (bnd) begin m_datos = win; m_valid = 1'b1; end
            if (c && bnd) err = 0;
            else if (c) begin
                err++;
                if (err >= 4) begin
                    m_state = 0; err = 0;
                    if (losses < 255) losses++;
                end
            end
        end
        m_comma = c;
        m_fase  = (n - r) % 10;
        n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        entrada = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== 26'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 26'd0);
        end
    endtask

    // Lock on RD- commas after two garbage bits.
    task automatic test_acquire_neg();
        int rise = -1, ncomma = 0, nvalid = 0;
        stim.delete();
        add_bits(10'b01, 2);
        repeat (3) add_word(KNEG);
        for (int i = 0; i < stim.size(); i++) begin
            drive_bit(stim[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL acq_neg_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (sincronizado && rise < 0) rise = i;
            if (comma_detectado) ncomma++;
            if (dato_valido) nvalid++;
        end
        checks++;
        if (rise != 31) begin errors++; $display("FAIL acq_neg_lock_edge: got %0d expected 31", rise); end
        checks++;
        if (ncomma != 3) begin errors++; $display("FAIL acq_neg_commas: got %0d expected 3", ncomma); end
        checks++;
        if (nvalid != 0) begin errors++; $display("FAIL acq_neg_valid: got %0d expected 0", nvalid); end
    endtask

    // Framed words after lock.
    task automatic test_words();
        logic [9:0] got[$];
        int         vidx[$];
        logic [9:0] want [3] = '{10'h155, 10'h2AA, 10'h17C};
        stim.delete();
        add_word(10'h155); add_word(10'h2AA); add_word(10'h17C);
        for (int i = 0; i < stim.size(); i++) begin
            drive_bit(stim[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL words_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (dato_valido) begin got.push_back(datos); vidx.push_back(i); end
        end
        checks++;
        if (got.size() != 3) begin
            errors++; $display("FAIL words_count: got %0d expected 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got[k] !== want[k] || vidx[k] != 9 + 10 * k) begin
                    errors++;
                    $display("FAIL words_%0d: got %h@%0d expected %h@%0d",
                             k, got[k], vidx[k], want[k], 9 + 10 * k);
                end
            end
        end
    endtask

    // Lock on RD+ commas.
    task automatic test_acquire_pos();
        int rise = -1, ncomma = 0;
        do_reset();
        stim.delete();
        add_bits(10'b10, 2);
        repeat (3) add_word(KPOS);
        for (int i = 0; i < stim.size(); i++) begin
            drive_bit(stim[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL acq_pos_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (sincronizado && rise < 0) rise = i;
            if (comma_detectado) ncomma++;
        end
        checks++;
        if (rise != 31) begin errors++; $display("FAIL acq_pos_lock_edge: got %0d expected 31", rise); end
        checks++;
        if (ncomma != 3) begin errors++; $display("FAIL acq_pos_commas: got %0d expected 3", ncomma); end
    endtask

    // Realign during ACQUIRE after a comma shifted by 5 bits.
    task automatic test_realign();
        int rise = -1;
        do_reset();
        stim.delete();
        add_bits(10'b01, 2);
        repeat (2) add_word(KNEG);
        add_bits(10'b10101, 5);
        add_word(KNEG);
        repeat (2) add_word(KNEG);
        for (int i = 0; i < stim.size(); i++) begin
            drive_bit(stim[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL realign_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (i == 36) begin
                checks++;
                if (fase !== 4'd0 || sincronizado !== 1'b0) begin
                    errors++;
                    $display("FAIL realign_shift: got fase=%0d sync=%b expected fase=0 sync=0",
                             fase, sincronizado);
                end
            end
            if (sincronizado && rise < 0) rise = i;
        end
        checks++;
        if (rise != 56) begin errors++; $display("FAIL realign_lock_edge: got %0d expected 56", rise); end
    endtask

    // Loss after 4 misaligned commas; 3 misaligned then aligned keeps sync.
    task automatic test_loss();
        int fall = -1;
        do_reset();
        stim.delete();
        add_bits(10'b01, 2);
        repeat (3) add_word(KNEG);
        add_word(10'h155);
        add_bits(10'b010, 3);
        repeat (4) add_word(KNEG);        // loss on the 4th (edge 84)
        repeat (3) add_word(KNEG);        // relock at edge 114
        repeat (2) begin
            add_bits(10'b010, 3);
            repeat (3) add_word(KNEG);
            add_bits(10'b1010101, 7);
            add_word(KNEG);               // aligned: clears err
        end
        add_word(10'h155);
        for (int i = 0; i < stim.size(); i++) begin
            drive_bit(stim[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL loss_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (i > 31 && !sincronizado && fall < 0) fall = i;
        end
        checks++;
        if (fall != 84) begin errors++; $display("FAIL loss_edge: got %0d expected 84", fall); end
        checks++;
        if (sincronizado !== 1'b1) begin
            errors++; $display("FAIL loss_err_clear: got sync=%b expected 1", sincronizado);
        end
    endtask

    // Asynchronous reset mid-word while synced.
    task automatic test_async_reset();
        logic [7:0] want_p;
`ifdef ALINEADOR_ESTADISTICAS_EN
        want_p = 8'd1;
`else
        want_p = 8'd0;
`endif
        checks++;
        if (perdidas_sync !== want_p) begin
            errors++; $display("FAIL perdidas_before_reset: got %0d expected %0d", perdidas_sync, want_p);
        end
        for (int k = 0; k < 4; k++) drive_bit(k[0]);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 26'd0) begin
            errors++; $display("FAIL async_reset: got %h expected %h", dut_vec(), 26'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        checks++;
        if (perdidas_sync !== 8'd0) begin
            errors++; $display("FAIL perdidas_after_reset: got %0d expected 0", perdidas_sync);
        end
    endtask

    // Random bits with commas sprinkled at random offsets.
    task automatic test_random();
        logic [9:0] w;
        stim.delete();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 11) == 0) begin
                w = $urandom_range(0, 1) ? KNEG : KPOS;
                add_word(w);
            end else begin
                stim.push_back(1'($urandom_range(0, 1)));
            end
        end
        for (int i = 0; i < stim.size(); i++) begin
            drive_bit(stim[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_acquire_neg();
        test_words();
        test_acquire_pos();
        test_realign();
        test_loss();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
